// File: rtl/bus_memory_bank_if.sv
// Command/status interface of one memory bank.
//   master : driven by the control unit (commands), reads busy/addr_out.
//   slave  : the bank itself.
// Signals:
//   enable          bank select; all commands ignored when 0
//   import_address  load address register from the shared bus
//   read            bank drives mem[addr] onto the shared bus
//   write           bank stores the shared bus value
//   overflow        write targets (addr+1) mod DEPTH instead of addr
//   auto_inc        post-increment addr after an accepted read or write
//   clear           start the clear sequence (pulse)
//   busy            1 while the clear sequence runs
//   addr_out        current address register
// The tri-state data/address bus itself is a plain inout port of the bank.
interface bus_memory_bank_if #(
  parameter int ADDR_W = 7
);
  logic              enable;
  logic              import_address;
  logic              read;
  logic              write;
  logic              overflow;
  logic              auto_inc;
  logic              clear;
  logic              busy;
  logic [ADDR_W-1:0] addr_out;

  modport master (
    output enable, import_address, read, write, overflow, auto_inc, clear,
    input  busy, addr_out
  );

  modport slave (
    input  enable, import_address, read, write, overflow, auto_inc, clear,
    output busy, addr_out
  );
endinterface

// File: rtl/bus_memory_bank.sv
// Word memory sitting on the shared tri-state matrix bus.
// One instance per storage bank, selected by ctl.enable.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high; restarts the clear sequence
//   bus    shared data/address bus (inout, released to Z unless reading)
//   ctl    command/status interface (slave side)
// Features: synchronous address import from the bus, auto-increment bursts,
// overflow writes to (addr+1) mod DEPTH, and a clear sequencer that zeroes
// one word per cycle after reset or on a clear command.
// Handshake: there is no valid/ready pair; a command is accepted on any
// rising edge where enable=1 and busy=0, and busy=1 means every command in
// that cycle is dropped. Reads are combinational; writes show up on the
// following cycle.
module bus_memory_bank #(
  parameter int DATA_W = 262,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clock,
  input  logic              reset,
  inout  wire  [DATA_W-1:0] bus,
  bus_memory_bank_if.slave  ctl
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              drive_en;
  logic [ADDR_W-1:0] imported_addr;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // Imported address is folded into range so DEPTH < 2**ADDR_W stays safe.
  assign imported_addr = ADDR_W'(32'(bus[ADDR_W-1:0]) % 32'(DEPTH));

  // State, address and clear pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      addr_q    <= '0;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state, address and the single memory write port
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_wa    = addr_q;
    mem_wd    = bus;
    case (state_q)
      ST_CLEAR: begin
        // Commands and enable are ignored; one word zeroed per cycle.
        mem_we = 1'b1;
        mem_wa = clr_ptr_q;
        mem_wd = '0;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (ctl.enable) begin
          if (ctl.clear) begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
          end else if (ctl.import_address) begin
            // Import suppresses any write or increment in the same cycle.
            addr_d = imported_addr;
          end else begin
            if (ctl.write) begin
              mem_we = 1'b1;
              mem_wa = ctl.overflow ? next_addr(addr_q) : addr_q;
            end
            if (ctl.auto_inc && (ctl.read || ctl.write)) begin
              addr_d = next_addr(addr_q);
            end
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Memory array: not reset; only the clear sequence zeroes it. While reset
  // is held the state sits in CLEAR with pointer 0, so word 0 is rewritten
  // with zero, which the restarted sequence does anyway.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Read path is combinational. During read&&write the bank's own drive is
  // what gets written back.
  assign drive_en = (state_q == ST_IDLE) && ctl.enable && ctl.read;
  assign bus      = drive_en ? mem[addr_q] : {DATA_W{1'bz}};

  // busy mirrors the FSM state directly (two-state machine).
  assign ctl.busy     = (state_q == ST_CLEAR);
  assign ctl.addr_out = addr_q;

endmodule

// File: tb/tb_bus_memory_bank.sv
module tb_bus_memory_bank;
  localparam int DATA_W = 262;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT hookup ----------------
  wire  [DATA_W-1:0] bus;
  logic [DATA_W-1:0] tb_data;
  logic              tb_oe;
  assign bus = tb_oe ? tb_data : {DATA_W{1'bz}};

  bus_memory_bank_if #(.ADDR_W(ADDR_W)) ctl ();

  bus_memory_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus),
    .ctl  (ctl)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mem_m [DEPTH];
  int                addr_m;
  int                clr_left;   // cycles of clearing still to run

  task automatic model_start_clear();
    // Nothing can be read while clearing, so the end result is all zeros.
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    clr_left = DEPTH;
  endtask

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  string             tag_q[$];
  bit                mon_en;
  int                n_checks;
  int                n_fail;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares the bus whenever the driver flagged a read cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bus_monitor: got read cycle, expected queue empty");
      end else begin
        check(tag_q.pop_front(), bus, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_cycle(input bit en, input bit imp, input bit rd,
                          input bit wr, input bit ov, input bit ai,
                          input bit clr, input logic [DATA_W-1:0] data,
                          input string tag);
    bit                driven;
    logic [DATA_W-1:0] busval;
    int                dest;
    driven = rd && en && (clr_left == 0);
    busval = driven ? mem_m[addr_m] : data;
    ctl.enable         = en;
    ctl.import_address = imp;
    ctl.read           = rd;
    ctl.write          = wr;
    ctl.overflow       = ov;
    ctl.auto_inc       = ai;
    ctl.clear          = clr;
    tb_oe              = !driven;
    tb_data            = data;
    if (rd) begin
      exp_q.push_back(busval);
      tag_q.push_back(tag);
      mon_en = 1'b1;
    end
    @(negedge clock);
    check("busy", DATA_W'(ctl.busy), DATA_W'(clr_left > 0));
    check("addr_out", DATA_W'(ctl.addr_out), DATA_W'(addr_m));
    // model update for this edge
    if (clr_left > 0) begin
      clr_left--;
    end else if (en) begin
      if (clr) begin
        model_start_clear();
      end else if (imp) begin
        addr_m = int'(busval[ADDR_W-1:0]) % DEPTH;
      end else begin
        if (wr) begin
          dest = ov ? (addr_m + 1) % DEPTH : addr_m;
          mem_m[dest] = busval;
        end
        if (ai && (rd || wr)) addr_m = (addr_m + 1) % DEPTH;
      end
    end
    @(posedge clock);
    #1;
    mon_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "idle");
  endtask

  task automatic imp_addr(input int a);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DATA_W'(a), "import");
  endtask

  task automatic rd_word(input bit ai, input string tag);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ai, 1'b0, '0, tag);
  endtask

  task automatic wr_word(input logic [DATA_W-1:0] d, input bit ov, input bit ai);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, ov, ai, 1'b0, d, "write");
  endtask

  // Enabled read attempts while busy: bank must stay off the bus (tb drives 0).
  task automatic busy_reads(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "bus_released_busy");
  endtask

  task automatic sweep(input string tag);
    imp_addr(0);
    for (int i = 0; i < DEPTH; i++) rd_word(1'b1, tag);
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < (DATA_W + 31) / 32; i++) w = {w[DATA_W-33:0], 32'($urandom())};
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    tb_oe    = 1'b1;
    tb_data  = '0;
    ctl.enable = 1'b0; ctl.import_address = 1'b0; ctl.read = 1'b0;
    ctl.write = 1'b0; ctl.overflow = 1'b0; ctl.auto_inc = 1'b0; ctl.clear = 1'b0;
    reset = 1'b1;
    addr_m = 0;
    model_start_clear();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // 1. Clear after reset, then spot reads.
    busy_reads(DEPTH);
    imp_addr(0);   rd_word(1'b0, "rd0_after_reset");
    imp_addr(63);  rd_word(1'b0, "rd63_after_reset");
    imp_addr(127); rd_word(1'b0, "rd127_after_reset");

    // 2. Simple write/read, bus released when not reading.
    imp_addr(5); wr_word(DATA_W'('hA5), 1'b0, 1'b0); rd_word(1'b0, "rd5_a5");
    imp_addr(6); rd_word(1'b0, "rd6_zero");
    imp_addr(5);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "bus_released_rd0");
    ctl.read = 1'b1;  // mark as checked cycle via the driver path
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "bus_released_en0");
    // read&&write, overflow=0: word must be unchanged
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, "rd_wr_same");
    rd_word(1'b0, "rd5_after_rdwr");

    // 3. Overflow write wraps; auto_inc wraps the address.
    imp_addr(127); wr_word(DATA_W'(1), 1'b1, 1'b0);
    imp_addr(0);   rd_word(1'b0, "rd0_overflow");
    imp_addr(127); rd_word(1'b0, "rd127_unchanged");
    wr_word(DATA_W'(2), 1'b0, 1'b1);
    check("addr_wrap", DATA_W'(ctl.addr_out), '0);

    // 4. Burst writes then burst reads.
    imp_addr(10);
    for (int i = 0; i < 4; i++) wr_word(DATA_W'('h11 + i), 1'b0, 1'b1);
    imp_addr(10);
    for (int i = 0; i < 4; i++) rd_word(1'b1, "burst_rd");
    check("burst_addr_end", DATA_W'(ctl.addr_out), DATA_W'(14));

    // 5. import+write together: address loads, memory untouched.
    do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DATA_W'('h20), "imp_wr");
    check("imp_wr_addr", DATA_W'(ctl.addr_out), DATA_W'(32));
    sweep("sweep_after_imp_wr");

    // 6. Clear mid-operation, then reset in the middle of a clear.
    imp_addr(5);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, "clear_cmd");
    busy_reads(DEPTH);
    sweep("sweep_after_clear");
    imp_addr(20); wr_word(rnd_word(), 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, "clear_cmd2");
    busy_reads(50);
    reset = 1'b1;
    addr_m = 0;
    model_start_clear();
    #2;
    check("reset_busy", DATA_W'(ctl.busy), DATA_W'(1));
    check("reset_addr", DATA_W'(ctl.addr_out), '0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    busy_reads(DEPTH);
    sweep("sweep_after_reset_clear");

    // 7. Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      do_cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 149) == 0), rnd_word(), "rand_rd");
    end
    while (clr_left > 0) idle(1);
    sweep("final_sweep");

    check("exp_q_drained", DATA_W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
